// File: rtl/mips32_regfile_dbg.sv
// MIPS32 register file: R0 hardwired to zero, combinational read ports
// with write-through bypass, plus a valid/ready register dump engine.
//
// Ports:
//   clk, reset (async, active-low)
//   we/waddr/wdata          : write port
//   raddr/rdata             : NUM_RD packed read ports
//   dump_start/first/last   : dump request and inclusive range
//   dump_valid/ready        : dump beat handshake
//   dump_idx/data           : current beat (zero when no beat)
//   dump_busy/done          : dump in progress / completion pulse
module mips32_regfile_dbg #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*AW-1:0]     raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     dump_start,
    input  logic [AW-1:0]            dump_first,
    input  logic [AW-1:0]            dump_last,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [AW-1:0]            dump_idx,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     dump_busy,
    output logic                     dump_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_e;

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];

    state_e            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [AW-1:0]     last_q, last_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [AW-1:0]     idx_inc;

    // Register value as seen this cycle, including a concurrent write.
    function automatic logic [DATA_W-1:0] rd_val(input logic [AW-1:0] a);
        if (a == '0) begin
            return '0;
        end
        if (we && (waddr == a)) begin
            return wdata;
        end
        return mem_q[a];
    endfunction

    always_comb begin
        rdata = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rdata[p*DATA_W +: DATA_W] = rd_val(raddr[p*AW +: AW]);
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != '0)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign idx_inc = idx_q + AW'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (dump_start) begin
                    last_d = dump_last;
                    if (dump_first <= dump_last) begin
                        state_d = S_SEND;
                        idx_d   = dump_first;
                        data_d  = rd_val(dump_first);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SEND: begin
                // Beat is a snapshot: only reloaded on acceptance.
                if (dump_ready) begin
                    if (idx_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d  = idx_inc;
                        data_d = rd_val(idx_inc);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign dump_valid = (state_q == S_SEND);
    assign dump_busy  = (state_q != S_IDLE);
    assign dump_done  = (state_q == S_DONE);
    assign dump_idx   = dump_valid ? idx_q : '0;
    assign dump_data  = dump_valid ? data_q : '0;

endmodule

// File: tb/tb_mips32_regfile_dbg.sv
// Directed testbench for mips32_regfile_dbg.
// Drives at posedge+1, checks at posedge+2.
module tb_mips32_regfile_dbg;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          reset;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [2*AW-1:0] raddr;
    logic [2*DW-1:0] rdata;
    logic          dump_start;
    logic [AW-1:0] dump_first;
    logic [AW-1:0] dump_last;
    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_idx;
    logic [DW-1:0] dump_data;
    logic          dump_busy;
    logic          dump_done;

    int checks;
    int failures;

    mips32_regfile_dbg dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr      (raddr),
        .rdata      (rdata),
        .dump_start (dump_start),
        .dump_first (dump_first),
        .dump_last  (dump_last),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        step();
        we    = 1'b0;
    endtask

    task automatic chk_beat(input string tag, input logic v,
                            input logic [AW-1:0] i,
                            input logic [DW-1:0] d);
        chk({tag, "_v"}, 64'(dump_valid), 64'(v));
        chk({tag, "_i"}, 64'(dump_idx), 64'(i));
        chk({tag, "_d"}, 64'(dump_data), 64'(d));
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        we         = 1'b0;
        waddr      = '0;
        wdata      = '0;
        raddr      = '0;
        dump_start = 1'b0;
        dump_first = '0;
        dump_last  = '0;
        dump_ready = 1'b0;

        step();
        chk("rst_valid", 64'(dump_valid), 64'd0);
        chk("rst_busy", 64'(dump_busy), 64'd0);
        chk("rst_done", 64'(dump_done), 64'd0);
        reset = 1'b1;
        step();

        // R5 write, R0 write discarded
        wr(5'd5, 32'h1234);
        wr(5'd0, 32'hFFFF);
        raddr = {5'd5, 5'd0};
        #1;
        chk("r5_r0", rdata, {32'h1234, 32'h0});

        // Bypass on port 1, port 0 independent
        we    = 1'b1;
        waddr = 5'd7;
        wdata = 32'hAA;
        raddr = {5'd7, 5'd5};
        #1;
        chk("bypass", rdata, {32'hAA, 32'h1234});
        step();
        we = 1'b0;
        #1;
        chk("r7_commit", rdata, {32'hAA, 32'h1234});

        // Bypass to R0 ignored
        we    = 1'b1;
        waddr = 5'd0;
        wdata = 32'h55;
        raddr = {5'd0, 5'd0};
        #1;
        chk("r0_nobyp", rdata, 64'd0);
        step();
        we = 1'b0;

        // Dump 1..3 with ready held high
        wr(5'd1, 32'd10);
        wr(5'd2, 32'd20);
        wr(5'd3, 32'd30);
        chk_beat("pre", 1'b0, 5'd0, 32'd0);
        dump_start = 1'b1;
        dump_first = 5'd1;
        dump_last  = 5'd3;
        dump_ready = 1'b1;
        step();
        dump_start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk_beat($sformatf("b%0d", i), 1'b1, AW'(i), DW'(i * 10));
            chk($sformatf("b%0d_busy", i), 64'(dump_busy), 64'd1);
            step();
        end
        #1;
        chk_beat("d13_done", 1'b0, 5'd0, 32'd0);
        chk("d13_dpulse", 64'(dump_done), 64'd1);
        chk("d13_dbusy", 64'(dump_busy), 64'd1);
        step();
        chk("d13_idle_b", 64'(dump_busy), 64'd0);
        chk("d13_idle_d", 64'(dump_done), 64'd0);

        // Dump 2..2 stalled, R2 rewritten during stall
        dump_start = 1'b1;
        dump_first = 5'd2;
        dump_last  = 5'd2;
        dump_ready = 1'b0;
        step();
        dump_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                we    = 1'b1;
                waddr = 5'd2;
                wdata = 32'd99;
            end
            #1;
            chk_beat($sformatf("stall%0d", i), 1'b1, 5'd2, 32'd20);
            step();
            we = 1'b0;
        end
        raddr = {5'd2, 5'd3};
        #1;
        chk("r2_new", rdata, {32'd99, 32'd30});
        dump_ready = 1'b1;
        step();
        chk("stall_done", 64'(dump_done), 64'd1);
        chk("stall_v", 64'(dump_valid), 64'd0);
        step();

        // Empty range; start held during DONE is ignored
        dump_start = 1'b1;
        dump_first = 5'd6;
        dump_last  = 5'd4;
        step();
        chk("empty_v", 64'(dump_valid), 64'd0);
        chk("empty_done", 64'(dump_done), 64'd1);
        chk("empty_busy", 64'(dump_busy), 64'd1);
        dump_first = 5'd1;
        dump_last  = 5'd1;
        step();
        dump_start = 1'b0;
        chk("ign_busy", 64'(dump_busy), 64'd0);
        chk("ign_v", 64'(dump_valid), 64'd0);
        step();
        chk("ign_idle", 64'(dump_busy), 64'd0);

        // Top of range, first beat bypasses a concurrent write
        wr(5'd31, 32'h31);
        dump_start = 1'b1;
        dump_first = 5'd30;
        dump_last  = 5'd31;
        we         = 1'b1;
        waddr      = 5'd30;
        wdata      = 32'h300;
        step();
        dump_start = 1'b0;
        we         = 1'b0;
        chk_beat("top30", 1'b1, 5'd30, 32'h300);
        step();
        chk_beat("top31", 1'b1, 5'd31, 32'h31);
        step();
        chk("top_done", 64'(dump_done), 64'd1);
        chk("top_nowrap", 64'(dump_valid), 64'd0);
        step();
        chk("top_idle", 64'(dump_busy), 64'd0);

        // Reset mid-dump of 0..31
        wr(5'd9, 32'h99);
        dump_start = 1'b1;
        dump_first = 5'd0;
        dump_last  = 5'd31;
        step();
        dump_start = 1'b0;
        chk_beat("rd0", 1'b1, 5'd0, 32'd0);
        step();
        chk_beat("rd1", 1'b1, 5'd1, 32'd10);
        #2;
        reset = 1'b0;
        #1;
        chk_beat("arst", 1'b0, 5'd0, 32'd0);
        chk("arst_busy", 64'(dump_busy), 64'd0);
        chk("arst_done", 64'(dump_done), 64'd0);
        raddr = {5'd9, 5'd1};
        #1;
        chk("arst_rd", rdata, 64'd0);
        step();
        reset = 1'b1;
        step();
        chk("post_busy", 64'(dump_busy), 64'd0);
        chk("post_done", 64'(dump_done), 64'd0);
        chk("post_rd", rdata, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
